id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that feeds the ALU in the pipelined core. On each clock it registers decoded operands and control from decode. Combinationally it drives `operand1`, `operand2` and `opSel` into the ALU, applying EX/MEM and MEM/WB forwarding. It also supports stall (hold), flush (bubble) and load-use hazard detection for the hazard unit.

## Interface
**Parameters**
- `data_width`, 32, datapath width
- `sel_width`, 3, ALU opSel width
- `addr_width`, 5, register address width

**Ports** (widths: D = `data_width`, S = `sel_width`, A = `addr_width`)
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `stall` in 1: hold the registered contents.
- `flush` in 1: load a bubble.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in D: register file read data.
- `id_imm` in D: immediate, already extended.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` in A: source and destination registers.
- `id_aluSrc` in 1: 1 selects the immediate as operand2.
- `id_opSel` in S: ALU operation (000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT).
- `id_regWrite`, `id_memRead`, `id_memWrite`, `id_memToReg` in 1: control bits.
- `exmem_regWrite` in 1, `exmem_rd` in A, `exmem_result` in D: forwarding source 1.
- `memwb_regWrite` in 1, `memwb_rd` in A, `memwb_data` in D: forwarding source 2.
- `ex_valid` out 1: EX slot holds a real instruction.
- `operand1`, `operand2` out D: to the ALU.
- `opSel` out S: to the ALU.
- `ex_store_data` out D: forwarded rt value, for stores.
- `ex_rd_addr` out A.
- `ex_regWrite`, `ex_memRead`, `ex_memWrite`, `ex_memToReg` out 1.
- `load_use_hazard` out 1: to the hazard unit.

## Operation
**Register update priority per edge:** reset > `flush` > `stall` > load.
- **Load:** capture all `id_*` fields. `ex_valid` <= `id_valid`.
- **Write-through on capture:** if `memwb_regWrite` is set, `memwb_rd` != 0 and `memwb_rd` equals `id_rs_addr` (or `id_rt_addr`), capture `memwb_data` in place of the regfile data.
- **Flush:** every register takes its reset value. This gives `ex_valid` = 0, all control bits 0 and opSel 000. Flush overrides stall.
- **Stall:** the entry is held, except that a held rs/rt value is overwritten by its currently selected forwarded value. This keeps the entry correct after the producer retires.

**Forwarding** (combinational, per source rs/rt; the source address is the registered one):
- If `exmem_regWrite` is set, `exmem_rd` != 0 and `exmem_rd` equals the source address, use `exmem_result`.
- Else, if `memwb_regWrite` is set, `memwb_rd` != 0 and `memwb_rd` equals the source address, use `memwb_data`.
- Else use the registered data.
- EX/MEM always wins over MEM/WB. Register 0 is never forwarded.

**Outputs:**
- `operand1` = forwarded rs.
- `ex_store_data` = forwarded rt.
- `operand2` = registered `aluSrc` ? registered imm : forwarded rt.
- `opSel`, `ex_rd_addr` and the control outputs come directly from registers.
- Control outputs are not gated by `ex_valid`; bubbles carry zeros by construction.

**Hazard detection:** `load_use_hazard` = `ex_valid` & `ex_memRead` & (`ex_rd_addr` != 0) & `id_valid` & (`ex_rd_addr` == `id_rs_addr` | `ex_rd_addr` == `id_rt_addr`). It is purely combinational; the hazard unit responds with an upstream stall plus `flush` of this stage.

**Widths:** all compares are exact A-bit equality. No arithmetic is performed in this block.

## Timing
- **Latency:** `id_*` sampled at edge N appears on the EX outputs after edge N. This is one cycle.
- **Combinational paths:** forwarding, operand2 selection and `load_use_hazard` settle within the same cycle as their inputs.
- **Reset:** asserting `rst` (low) immediately forces every register and registered output to 0: `ex_valid` = 0, `opSel` = 000, `ex_rd_addr` = 0, all controls 0. `operand1`/`operand2`/`ex_store_data` are then 0 unless forwarding is active.
- **Reset mid-stall:** the held instruction is discarded. On release, the first edge loads normally.
- **Simultaneous `flush` and `stall`:** the edge loads a bubble.
- **Sustained stall:** multiple held cycles must preserve the entry; forwarded updates accumulate correctly.

## Test plan
- **Basic load:** load `id_opSel` = 001, rs data = 10, rt data = 3, aluSrc = 0. -> The next cycle shows `operand1` = 10, `operand2` = 3, `opSel` = 001, `ex_valid` = 1.
- **Forward priority:** registered rs = r5, with `exmem` (rd = 5, result = 0x11) and `memwb` (rd = 5, data = 0x22) both writing. -> `operand1` = 0x11. Drop `exmem_regWrite` -> 0x22. Set rd = 0 on both -> registered data.
- **Load-use:** EX holds `memRead` with rd = 7 and `ex_valid` = 1, while ID has `id_rt_addr` = 7. -> `load_use_hazard` = 1. Pulse `flush` -> next cycle `ex_valid` = 0, all controls 0, `load_use_hazard` = 0.
- **Stall capture:** stall with rs = r3 held and `memwb` (rd = 3, data = 0x55) for one cycle, then `memwb` idle, then release stall. -> `operand1` remains 0x55 throughout.
- **Reset and flush priority:** assert `rst` low asynchronously mid-cycle during a stall -> outputs go to 0 immediately without waiting for an edge. Separately, assert `flush` and `stall` together -> a bubble is loaded.
- **Immediate select:** `id_aluSrc` = 1, imm = 0xFFFFFFFC, rt forwarded = 9. -> `operand2` = 0xFFFFFFFC and `ex_store_data` = 9.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands/control,
// forwards from EX/MEM and MEM/WB, and flags load-use hazards for the hazard unit.
module id_ex_stage #(
  parameter int unsigned data_width = 32,
  parameter int unsigned sel_width  = 3,
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [data_width-1:0] id_rs_data,
  input  logic [data_width-1:0] id_rt_data,
  input  logic [data_width-1:0] id_imm,
  input  logic [addr_width-1:0] id_rs_addr,
  input  logic [addr_width-1:0] id_rt_addr,
  input  logic [addr_width-1:0] id_rd_addr,
  input  logic                  id_aluSrc,
  input  logic [sel_width-1:0]  id_opSel,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  id_memWrite,
  input  logic                  id_memToReg,
  input  logic                  exmem_regWrite,
  input  logic [addr_width-1:0] exmem_rd,
  input  logic [data_width-1:0] exmem_result,
  input  logic                  memwb_regWrite,
  input  logic [addr_width-1:0] memwb_rd,
  input  logic [data_width-1:0] memwb_data,
  output logic                  ex_valid,
  output logic [data_width-1:0] operand1,
  output logic [data_width-1:0] operand2,
  output logic [sel_width-1:0]  opSel,
  output logic [data_width-1:0] ex_store_data,
  output logic [addr_width-1:0] ex_rd_addr,
  output logic                  ex_regWrite,
  output logic                  ex_memRead,
  output logic                  ex_memWrite,
  output logic                  ex_memToReg,
  output logic                  load_use_hazard
);

  logic                  valid_q,    valid_d;
  logic [data_width-1:0] rs_data_q,  rs_data_d;
  logic [data_width-1:0] rt_data_q,  rt_data_d;
  logic [data_width-1:0] imm_q,      imm_d;
  logic [addr_width-1:0] rs_addr_q,  rs_addr_d;
  logic [addr_width-1:0] rt_addr_q,  rt_addr_d;
  logic [addr_width-1:0] rd_addr_q,  rd_addr_d;
  logic                  alu_src_q,  alu_src_d;
  logic [sel_width-1:0]  op_sel_q,   op_sel_d;
  logic                  reg_wr_q,   reg_wr_d;
  logic                  mem_rd_q,   mem_rd_d;
  logic                  mem_wr_q,   mem_wr_d;
  logic                  mem2reg_q,  mem2reg_d;

  logic [data_width-1:0] fwd_rs, fwd_rt;
  logic [data_width-1:0] cap_rs, cap_rt;

  // Forwarding on the registered source addresses; EX/MEM beats MEM/WB, r0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rs_addr_q))
      fwd_rs = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rs_addr_q))
      fwd_rs = memwb_data;

    fwd_rt = rt_data_q;
    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rt_addr_q))
      fwd_rt = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rt_addr_q))
      fwd_rt = memwb_data;
  end

  // Write-through: a same-cycle WB write is not yet visible in the regfile read data.
  always_comb begin
    cap_rs = id_rs_data;
    if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == id_rs_addr))
      cap_rs = memwb_data;
    cap_rt = id_rt_data;
    if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == id_rt_addr))
      cap_rt = memwb_data;
  end

  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    alu_src_d = alu_src_q;
    op_sel_d  = op_sel_q;
    reg_wr_d  = reg_wr_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    mem2reg_d = mem2reg_q;
    if (flush) begin
      valid_d   = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      alu_src_d = 1'b0;
      op_sel_d  = '0;
      reg_wr_d  = 1'b0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      mem2reg_d = 1'b0;
    end else if (stall) begin
      // Absorb forwarded values so the entry survives its producer retiring.
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
    end else begin
      valid_d   = id_valid;
      rs_data_d = cap_rs;
      rt_data_d = cap_rt;
      imm_d     = id_imm;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      rd_addr_d = id_rd_addr;
      alu_src_d = id_aluSrc;
      op_sel_d  = id_opSel;
      reg_wr_d  = id_regWrite;
      mem_rd_d  = id_memRead;
      mem_wr_d  = id_memWrite;
      mem2reg_d = id_memToReg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      alu_src_q <= 1'b0;
      op_sel_q  <= '0;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem2reg_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      alu_src_q <= alu_src_d;
      op_sel_q  <= op_sel_d;
      reg_wr_q  <= reg_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      mem2reg_q <= mem2reg_d;
    end
  end

  assign ex_valid      = valid_q;
  assign operand1      = fwd_rs;
  assign ex_store_data = fwd_rt;
  assign operand2      = alu_src_q ? imm_q : fwd_rt;
  assign opSel         = op_sel_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_regWrite   = reg_wr_q;
  assign ex_memRead    = mem_rd_q;
  assign ex_memWrite   = mem_wr_q;
  assign ex_memToReg   = mem2reg_q;

  assign load_use_hazard = valid_q && mem_rd_q && (rd_addr_q != '0) && id_valid &&
                           ((rd_addr_q == id_rs_addr) || (rd_addr_q == id_rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an entry-level reference model checked every cycle,
// plus hand-computed directed expectations for the named scenarios.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_aluSrc;
  logic [2:0]  id_opSel;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic        exmem_regWrite, memwb_regWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, load_use_hazard;
  logic [31:0] operand1, operand2, ex_store_data;
  logic [2:0]  opSel;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  id_ex_stage #(.data_width(32), .sel_width(3), .addr_width(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_aluSrc(id_aluSrc), .id_opSel(id_opSel), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
    .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .operand1(operand1), .operand2(operand2), .opSel(opSel),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction occupying the EX slot.
  typedef struct {
    logic        valid;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rsa, rta, rd;
    logic        alusrc;
    logic [2:0]  op;
    logic        rw, mr, mw, m2r;
  } ent_t;

  ent_t m;
  ent_t bubble = '{valid: 1'b0, rs: 32'd0, rt: 32'd0, imm: 32'd0, rsa: 5'd0, rta: 5'd0,
                   rd: 5'd0, alusrc: 1'b0, op: 3'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0};

  function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] v);
    if (exmem_regWrite && exmem_rd == a && a != 5'd0) return exmem_result;
    if (memwb_regWrite && memwb_rd == a && a != 5'd0) return memwb_data;
    return v;
  endfunction

  function automatic logic [31:0] wb_value(input logic [4:0] a, input logic [31:0] v);
    return (memwb_regWrite && memwb_rd == a && a != 5'd0) ? memwb_data : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m = bubble;
    else if (flush) m = bubble;
    else if (stall) begin
      m.rs = newest(m.rsa, m.rs);
      m.rt = newest(m.rta, m.rt);
    end else begin
      m = '{valid: id_valid, rs: wb_value(id_rs_addr, id_rs_data),
            rt: wb_value(id_rt_addr, id_rt_data), imm: id_imm,
            rsa: id_rs_addr, rta: id_rt_addr, rd: id_rd_addr, alusrc: id_aluSrc,
            op: id_opSel, rw: id_regWrite, mr: id_memRead, mw: id_memWrite,
            m2r: id_memToReg};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [31:0] e_rt;
      logic        e_haz;
      e_rt  = newest(m.rta, m.rt);
      e_haz = m.valid && m.mr && m.rd != 5'd0 && id_valid &&
              (m.rd == id_rs_addr || m.rd == id_rt_addr);
      chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      chk("m_operand1", operand1, newest(m.rsa, m.rs));
      chk("m_operand2", operand2, m.alusrc ? m.imm : e_rt);
      chk("m_store",    ex_store_data, e_rt);
      chk("m_opsel",    {29'd0, opSel}, {29'd0, m.op});
      chk("m_rd",       {27'd0, ex_rd_addr}, {27'd0, m.rd});
      chk("m_ctrl",     {28'd0, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg},
                        {28'd0, m.rw, m.mr, m.mw, m.m2r});
      chk("m_hazard",   {31'd0, load_use_hazard}, {31'd0, e_haz});
    end
  end

  task automatic idle();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_aluSrc = 0; id_opSel = 0;
    id_regWrite = 0; id_memRead = 0; id_memWrite = 0; id_memToReg = 0;
    exmem_regWrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regWrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rsa, input logic [31:0] rsd,
                      input logic [4:0] rta, input logic [31:0] rtd,
                      input logic [4:0] rd, input logic [2:0] op);
    id_valid = 1; id_rs_addr = rsa; id_rs_data = rsd;
    id_rt_addr = rta; id_rt_data = rtd; id_rd_addr = rd; id_opSel = op;
    id_regWrite = 1;
  endtask

  initial begin
    idle();
    #1 rst = 0;
    #2;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_op1",   operand1, 32'd0);
    @(negedge clk);
    rst = 1;
    run_cmp = 1;

    // Basic load
    load(5'd1, 32'd10, 5'd2, 32'd3, 5'd4, 3'b001);
    cyc();
    idle();
    #1;
    chk("basic_op1",   operand1, 32'd10);
    chk("basic_op2",   operand2, 32'd3);
    chk("basic_opsel", {29'd0, opSel}, 32'd1);
    chk("basic_valid", {31'd0, ex_valid}, 32'd1);

    // Forward priority
    load(5'd5, 32'h99, 5'd0, 32'd0, 5'd6, 3'b000);
    cyc();
    idle();
    exmem_regWrite = 1; exmem_rd = 5; exmem_result = 32'h11;
    memwb_regWrite = 1; memwb_rd = 5; memwb_data = 32'h22;
    #1 chk("fwd_exmem", operand1, 32'h11);
    exmem_regWrite = 0;
    #1 chk("fwd_memwb", operand1, 32'h22);
    exmem_regWrite = 1; exmem_rd = 0; memwb_rd = 0;
    #1 chk("fwd_r0", operand1, 32'h99);
    cyc();
    idle();

    // Load-use hazard then flush
    load(5'd1, 32'd0, 5'd2, 32'd0, 5'd7, 3'b000);
    id_memRead = 1; id_memToReg = 1;
    cyc();
    idle();
    id_valid = 1; id_rs_addr = 1; id_rt_addr = 7;
    #1 chk("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    id_valid = 0;
    #1 chk("lu_idvalid0", {31'd0, load_use_hazard}, 32'd0);
    id_valid = 1;
    flush = 1;
    cyc();
    flush = 0;
    #1;
    chk("lu_flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_flush_ctrl",  {28'd0, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg}, 32'd0);
    chk("lu_flush_haz",   {31'd0, load_use_hazard}, 32'd0);
    idle();

    // Stall capture across producer retirement
    load(5'd3, 32'h33, 5'd0, 32'd0, 5'd8, 3'b010);
    cyc();
    idle();
    stall = 1; id_valid = 1; id_rs_addr = 3; id_rs_data = 32'hAA;
    memwb_regWrite = 1; memwb_rd = 3; memwb_data = 32'h55;
    #1 chk("stall_fwd", operand1, 32'h55);
    cyc();
    memwb_regWrite = 0; memwb_rd = 0; memwb_data = 0;
    #1 chk("stall_held1", operand1, 32'h55);
    cyc();
    chk("stall_held2", operand1, 32'h55);
    stall = 0;
    #1 chk("stall_release", operand1, 32'h55);
    cyc();
    idle();

    // Reset asserted mid-cycle during a stall
    load(5'd4, 32'h44, 5'd0, 32'd0, 5'd9, 3'b011);
    id_memWrite = 1;
    cyc();
    idle();
    stall = 1;
    cyc();
    #2 rst = 0;
    #1;
    chk("rst_async_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_async_op1",   operand1, 32'd0);
    chk("rst_async_opsel", {29'd0, opSel}, 32'd0);
    chk("rst_async_ctrl",  {28'd0, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg}, 32'd0);
    @(negedge clk);
    rst = 1; stall = 0;
    load(5'd2, 32'h123, 5'd0, 32'd0, 5'd3, 3'b100);
    cyc();
    idle();
    chk("rst_release_load", operand1, 32'h123);

    // Flush and stall together
    load(5'd2, 32'h7, 5'd0, 32'd0, 5'd3, 3'b010);
    cyc();
    flush = 1; stall = 1;
    cyc();
    idle();
    chk("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_stall_opsel", {29'd0, opSel}, 32'd0);

    // Immediate select with forwarded rt
    load(5'd0, 32'd0, 5'd6, 32'd1, 5'd2, 3'b000);
    id_aluSrc = 1; id_imm = 32'hFFFF_FFFC;
    cyc();
    idle();
    memwb_regWrite = 1; memwb_rd = 6; memwb_data = 32'd9;
    #1;
    chk("imm_op2",   operand2, 32'hFFFF_FFFC);
    chk("imm_store", ex_store_data, 32'd9);
    idle();

    // Write-through on capture; r0 never written through
    load(5'd8, 32'h1, 5'd0, 32'h5, 5'd1, 3'b000);
    memwb_regWrite = 1; memwb_rd = 8; memwb_data = 32'h77;
    cyc();
    idle();
    chk("wt_rs", operand1, 32'h77);
    load(5'd1, 32'h2, 5'd0, 32'h5, 5'd1, 3'b000);
    memwb_regWrite = 1; memwb_rd = 0; memwb_data = 32'h66;
    cyc();
    idle();
    chk("wt_r0", ex_store_data, 32'h5);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      id_valid = 1'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs_addr = 5'($urandom_range(0, 7));
      id_rt_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_aluSrc = 1'($urandom); id_opSel = 3'($urandom_range(0, 4));
      id_regWrite = 1'($urandom); id_memRead = 1'($urandom);
      id_memWrite = 1'($urandom); id_memToReg = 1'($urandom);
      exmem_regWrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regWrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_data = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    idle();
    @(negedge clk);
    #1;
    run_cmp = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
